// File: rtl/pc_with_lut.sv
// pc_with_lut: fetch-stage program counter with a read-only jump-target table.
// The PC increments by one on every clock. An absolute jump loads the target
// for the current branch label instead.
module pc_with_lut #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         absjump_en,
  input  logic [7:0]   addr,
  output logic [D-1:0] target,
  output logic [D-1:0] prog_ctr
);

  logic [D-1:0] target_s;
  logic [D-1:0] pc_next_s;
  logic [D-1:0] prog_ctr_r;

  // Jump-target table. Unlisted labels are reserved and read as 0.
  // Each value is cast to D bits, so it is truncated when D is too narrow.
  function automatic logic [D-1:0] jump_lut(input logic [7:0] label);
    logic [D-1:0] val;
    case (label)
      8'd0:    val = D'(32'd6);
      8'd18:   val = D'(32'd101);
      default: val = D'(32'd0);
    endcase
    return val;
  endfunction

  // Combinational table lookup. It follows addr with no clock.
  always_comb begin
    target_s = jump_lut(addr);
  end

  // Next PC. A jump loads the table value. Otherwise the PC increments and
  // wraps modulo 2^D. An unknown enable falls through to the increment branch.
  always_comb begin
    pc_next_s = prog_ctr_r;
    if (absjump_en) begin
      pc_next_s = target_s;
    end else begin
      pc_next_s = prog_ctr_r + D'(32'd1);
    end
  end

  // PC register. Reset clears it asynchronously and overrides any jump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ctr_r <= '0;
    end else begin
      prog_ctr_r <= pc_next_s;
    end
  end

  assign target   = target_s;
  assign prog_ctr = prog_ctr_r;

endmodule

// File: tb/tb_pc_with_lut.sv
// Directed self-checking bench for pc_with_lut using hand-computed expectations.
module tb_pc_with_lut;

  localparam int D = 12;

  logic         clk;
  logic         reset;
  logic         absjump_en;
  logic [7:0]   addr;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;

  int n_cmp = 0;
  int n_err = 0;

  pc_with_lut #(.D(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .absjump_en (absjump_en),
    .addr       (addr),
    .target     (target),
    .prog_ctr   (prog_ctr)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns past it before sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b0;
    absjump_en = 1'b0;
    addr       = 8'd0;

    // Reset is asserted before the first clock edge.
    #1 reset = 1'b1;
    #1 check_val("reset_async", prog_ctr, 12'd0);
    absjump_en = 1'b1;
    addr       = 8'd18;
    tick(1);
    check_val("reset_hold_over_jump", prog_ctr, 12'd0);

    // Free run.
    reset      = 1'b0;
    absjump_en = 1'b0;
    tick(10);
    check_val("free_run_10", prog_ctr, 12'd10);

    // Jump to label 0.
    reset = 1'b1;
    #1 check_val("reset_mid_cycle", prog_ctr, 12'd0);
    tick(1);
    reset      = 1'b0;
    absjump_en = 1'b1;
    addr       = 8'd0;
    #1 check_val("target_lbl0", target, 12'd6);
    tick(1);
    check_val("jump_lbl0", prog_ctr, 12'd6);
    absjump_en = 1'b0;
    tick(1);
    check_val("inc_after_jump0", prog_ctr, 12'd7);

    // Jump to label 18, then run.
    reset = 1'b1;
    #1;
    tick(1);
    reset      = 1'b0;
    absjump_en = 1'b1;
    addr       = 8'd18;
    #1 check_val("target_lbl18", target, 12'd101);
    tick(1);
    check_val("jump_lbl18", prog_ctr, 12'd101);
    absjump_en = 1'b0;
    tick(10);
    check_val("run_after_jump18", prog_ctr, 12'd111);

    // Reserved labels read as 0.
    addr = 8'd17;
    #1 check_val("target_lbl17", target, 12'd0);
    addr = 8'd255;
    #1 check_val("target_lbl255", target, 12'd0);
    addr = 8'd1;
    #1 check_val("target_lbl1", target, 12'd0);

    // Wrap at 2^D, then a sustained jump.
    reset = 1'b1;
    #1;
    tick(1);
    reset = 1'b0;
    tick(4095);
    check_val("pre_wrap", prog_ctr, 12'd4095);
    tick(1);
    check_val("wrap", prog_ctr, 12'd0);
    absjump_en = 1'b1;
    addr       = 8'd18;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("sustained_jump", prog_ctr, 12'd101);
    end

    // Only the label present at the edge matters.
    addr = 8'd0;
    #2 addr = 8'd18;
    tick(1);
    check_val("label_at_edge", prog_ctr, 12'd101);
    absjump_en = 1'b0;
    tick(1);
    check_val("inc_after_stall", prog_ctr, 12'd102);

    // Reset mid-run discards a simultaneous jump.
    reset = 1'b1;
    #1;
    tick(1);
    reset = 1'b0;
    tick(50);
    check_val("reach_50", prog_ctr, 12'd50);
    #2;
    absjump_en = 1'b1;
    addr       = 8'd18;
    reset      = 1'b1;
    #1 check_val("reset_mid_run", prog_ctr, 12'd0);
    tick(1);
    check_val("reset_ignores_jump", prog_ctr, 12'd0);
    reset      = 1'b0;
    absjump_en = 1'b0;
    tick(1);
    check_val("first_inc_after_reset", prog_ctr, 12'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
